gpio_port_irq: RTL and testbench
================================

Name: gpio_port_irq

Overview:
- Parametrised successor GPIO peripheral on the memory-mapped peripheral bus (ce/wr_en/addr/wdata/rdata, single-cycle).
- Drives N_PINS bidirectional pads with per-pin direction.
- Inputs pass through a synchroniser.
- Atomic set/reset of output bits.
- Per-pin rising/falling edge detection into a sticky write-1-to-clear pending register, plus a single level interrupt line to the core.

Parameters:
- N_PINS, 8, number of pads (1..16); register bits above N_PINS-1 read 0 and ignore writes.
- SYNC_STAGES, 2, synchroniser flops per input (2 or 3).
- DB_CYCLES, 4, debounce stability count (used only with GPIO_DEBOUNCE_EN; 2..255).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- ce  input  1  peripheral select.
- wr_en  input  1  write strobe (qualified by ce).
- addr  input  5  byte address; addr[4:2] selects word, addr[1:0] ignored.
- wdata  input  32  write data.
- rdata  output  32  combinational read data.
- irq  output  1  level interrupt, high while any pending bit is set.
- IOPort  inout  N_PINS  pads.

Behaviour:
- Reset (async on reset_n low, released synchronously by design): MODER, ODR, RISE_EN, FALL_EN, ISR = 0. All synchroniser/prev flops = 0. irq = 0. All pads high-Z.
- Register map (addr[4:2]):
  - 0 MODER (RW): 1 = output.
  - 1 IDR (RO): synchronised pad value.
  - 2 ODR (RW).
  - 3 BSRR (WO, reads 0): wdata[15:0] set ODR bits, wdata[31:16] clear ODR bits. Set wins if both are given for the same bit.
  - 4 RISE_EN (RW).
  - 5 FALL_EN (RW).
  - 6 ISR (R/W1C).
  - 7 reserved: reads 0, writes ignored.
- Writes take effect on the clk edge where ce & wr_en. Reads have no side effects. ce low: rdata = 0.
- Pad drive: IOPort[i] = MODER[i] ? ODR[i] : Z.
- Input path:
  - Every pad is sampled through a SYNC_STAGES flop chain regardless of mode, so output pins read back their driven value.
  - IDR = last sync stage.
  - A pad change settling before edge E0 appears in IDR after edge E(SYNC_STAGES-1).
- Edge detect:
  - prev[i] registers IDR[i].
  - rise = IDR & ~prev; fall = ~IDR & prev.
  - Detection is qualified by ~MODER[i]; output pins never flag.
  - ISR[i] is set on the clk edge following the cycle where (rise & RISE_EN) | (fall & FALL_EN). Total pin-to-ISR latency is SYNC_STAGES+1 edges.
- ISR clear: write 1 clears the bit, write 0 has no effect. A new set event in the same cycle as a W1C of the same bit wins (bit stays 1).
- irq = |ISR, combinational from ISR, with no extra register.
- Enable changes do not clear ISR. Changing MODER input to output mid-edge suppresses detection from the next cycle.
- Reset mid-operation: all state returns to reset values immediately, pads release to Z.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined:
  - Per-pin counter, width ceil(log2(DB_CYCLES+1)).
  - IDR[i] takes the sync-stage value only after that value has differed from IDR[i] for DB_CYCLES consecutive clocks. The counter restarts whenever the sync value returns to IDR[i].
  - Glitches shorter than DB_CYCLES clocks never reach IDR/ISR.
  - Latency grows by DB_CYCLES edges.
- Undefined: no counters; IDR is the direct sync-stage output; DB_CYCLES unused.

Test Plan:
- Reset, then read all 8 words -> MODER/ODR/IDR(pads pulled 0)/BSRR/RISE_EN/FALL_EN/ISR/reserved all 0x00000000; irq=0; IOPort all Z.
- MODER=0x0F, ODR=0xA5, then BSRR=0x00F0_0003 -> ODR reads 0x07 (bits 4-7 cleared; bits 0,1 set); IOPort[3:0]=4'b0111, IOPort[7:4]=Z; IDR[3:0]=0x7 after SYNC_STAGES edges.
- BSRR=0x0001_0001 -> ODR[0]=1 (set wins).
- RISE_EN=0x10, drive IOPort[4] 0->1 -> ISR=0x10 and irq=1 exactly SYNC_STAGES+1 edges later.
- Drive 1->0 on IOPort[4] -> no new flag.
- Write ISR=0x10 -> ISR=0, irq=0.
- FALL_EN=0x20, drive IOPort[5] 1->0 timed so the set cycle coincides with a W1C write of 0x20 -> ISR[5]=1 (set wins).
- Output pin 0 toggled via ODR with RISE_EN[0]=1 -> ISR[0] stays 0.
- GPIO_DEBOUNCE_EN, DB_CYCLES=4:
  - 3-cycle pulse on IOPort[2] (RISE_EN=0x04) -> IDR[2] and ISR unchanged.
  - 6-cycle pulse -> IDR[2]=1 and ISR[2]=1 after SYNC_STAGES+4(+1) edges.
- Assert reset_n low mid-pulse with ISR=0x10, MODER=0xFF -> ISR=0, irq=0, pads Z immediately, before the next clk edge.

Source files
------------

// File: rtl/gpio_port_irq.sv
// GPIO port with per-pin direction, BSRR atomic set/clear, synchronised inputs and
// edge-triggered W1C interrupts. Optional input debounce when GPIO_DEBOUNCE_EN is defined.
module gpio_port_irq #(
    parameter int unsigned N_PINS      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_CYCLES   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              wr_en,
    input  logic [4:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irq,
    inout  wire  [N_PINS-1:0] IOPort
);

    logic [N_PINS-1:0] moder_q, moder_d;
    logic [N_PINS-1:0] odr_q, odr_d;
    logic [N_PINS-1:0] rise_en_q, rise_en_d;
    logic [N_PINS-1:0] fall_en_q, fall_en_d;
    logic [N_PINS-1:0] isr_q, isr_d;
    logic [N_PINS-1:0] prev_q, prev_d;
    logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_q, sync_d;

    logic [N_PINS-1:0] idr;
    logic [N_PINS-1:0] rise, fall, set_ev;
    logic [2:0]        sel;
    logic              wr;
    logic              unused_ok;

    assign sel       = addr[4:2];
    assign wr        = ce & wr_en;
    assign unused_ok = ^{addr[1:0], wdata};

    for (genvar i = 0; i < N_PINS; i++) begin : g_pad
        assign IOPort[i] = moder_q[i] ? odr_q[i] : 1'bz;
    end

    always_comb begin
        sync_d[0] = IOPort;
        for (int s = 1; s < int'(SYNC_STAGES); s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

    logic [N_PINS-1:0][CntW-1:0] db_cnt_q, db_cnt_d;
    logic [N_PINS-1:0]           idr_q, idr_d;

    // A pin only updates after its synced value has disagreed for DB_CYCLES clocks in a row.
    always_comb begin
        idr_d    = idr_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < int'(N_PINS); i++) begin
            if (sync_q[SYNC_STAGES-1][i] != idr_q[i]) begin
                if (db_cnt_q[i] == CntW'(DB_CYCLES - 1)) begin
                    idr_d[i]    = sync_q[SYNC_STAGES-1][i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CntW'(1);
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idr_q    <= '0;
            db_cnt_q <= '0;
        end else begin
            idr_q    <= idr_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign idr = idr_q;
`else
    localparam int unsigned UnusedDbCycles = DB_CYCLES;

    assign idr = sync_q[SYNC_STAGES-1];
`endif

    assign rise   = idr & ~prev_q;
    assign fall   = ~idr & prev_q;
    assign set_ev = ((rise & rise_en_q) | (fall & fall_en_q)) & ~moder_q;
    assign prev_d = idr;

    always_comb begin
        moder_d   = moder_q;
        odr_d     = odr_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        isr_d     = isr_q;
        if (wr) begin
            case (sel)
                3'd0: moder_d = wdata[N_PINS-1:0];
                3'd2: odr_d = wdata[N_PINS-1:0];
                // Clear first, then set, so set wins on a collision.
                3'd3: odr_d = (odr_q & ~wdata[16 +: N_PINS]) | wdata[N_PINS-1:0];
                3'd4: rise_en_d = wdata[N_PINS-1:0];
                3'd5: fall_en_d = wdata[N_PINS-1:0];
                3'd6: isr_d = isr_q & ~wdata[N_PINS-1:0];
                default: ;
            endcase
        end
        isr_d = isr_d | set_ev;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            moder_q   <= '0;
            odr_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            isr_q     <= '0;
            prev_q    <= '0;
            sync_q    <= '0;
        end else begin
            moder_q   <= moder_d;
            odr_q     <= odr_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            isr_q     <= isr_d;
            prev_q    <= prev_d;
            sync_q    <= sync_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (ce) begin
            case (sel)
                3'd0: rdata[N_PINS-1:0] = moder_q;
                3'd1: rdata[N_PINS-1:0] = idr;
                3'd2: rdata[N_PINS-1:0] = odr_q;
                3'd4: rdata[N_PINS-1:0] = rise_en_q;
                3'd5: rdata[N_PINS-1:0] = fall_en_q;
                3'd6: rdata[N_PINS-1:0] = isr_q;
                default: rdata = '0;
            endcase
        end
    end

    assign irq = |isr_q;

endmodule

// File: tb/tb_gpio_port_irq.sv
// Directed self-checking bench for gpio_port_irq; pads are driven by per-bit tristate drivers.
module tb_gpio_port_irq;

    localparam int SYNC = 2;
    localparam int DBC  = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = SYNC + DBC;
`else
    localparam int LAT = SYNC;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;
    wire  [7:0]  pad;
    logic [7:0]  tb_oe = 8'hFF;
    logic [7:0]  tb_val = 8'h00;

    int n_tests = 0;
    int n_fail = 0;

    for (genvar g = 0; g < 8; g++) begin : g_drv
        assign pad[g] = tb_oe[g] ? tb_val[g] : 1'bz;
    end

    gpio_port_irq #(
        .N_PINS     (8),
        .SYNC_STAGES(SYNC),
        .DB_CYCLES  (DBC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .ce     (ce),
        .wr_en  (wr_en),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq),
        .IOPort (pad)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [2:0] w, input logic [31:0] d);
        addr = {w, 2'b00};
        wdata = d;
        ce = 1'b1;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] w, output logic [31:0] v);
        addr = {w, 2'b00};
        ce = 1'b1;
        wr_en = 1'b0;
        #1;
        v = rdata;
        ce = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset_n = 1'b0;
        tb_oe = 8'hFF;
        tb_val = 8'h00;
        cycles(3);
        reset_n = 1'b1;
        cycles(LAT + 2);
        for (int w = 0; w < 8; w++) begin
            rd(3'(w), v);
            n_tests++;
            if (v !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_word%0d: got %h want 00000000", w, v);
            end
        end
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
        tb_val = 8'h5A;
        #1;
        n_tests++;
        if (pad !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_pads_z: got %h want 5a", pad);
        end
        tb_val = 8'h00;
        cycles(LAT + 3);
    endtask

    task automatic test_bsrr;
        logic [31:0] v;
        wr(3'd0, 32'h0F);
        tb_oe = 8'hF0;
        tb_val = 8'h90;
        wr(3'd2, 32'hA5);
        wr(3'd3, 32'h00F0_0003);
        rd(3'd2, v);
        n_tests++;
        if (v !== 32'h07) begin
            n_fail++;
            $display("FAIL bsrr_odr: got %h want 00000007", v);
        end
        n_tests++;
        if (pad[3:0] !== 4'b0111) begin
            n_fail++;
            $display("FAIL bsrr_pad_low: got %b want 0111", pad[3:0]);
        end
        n_tests++;
        if (pad[7:4] !== 4'b1001) begin
            n_fail++;
            $display("FAIL bsrr_pad_high_z: got %b want 1001", pad[7:4]);
        end
        addr = 5'b01000;
        #1;
        n_tests++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL ce_low_rdata: got %h want 00000000", rdata);
        end
        cycles(LAT);
        rd(3'd1, v);
        n_tests++;
        if (v !== 32'h97) begin
            n_fail++;
            $display("FAIL idr_readback: got %h want 00000097", v);
        end
        rd(3'd3, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL bsrr_reads0: got %h want 00000000", v);
        end
        wr(3'd3, 32'h0001_0000);
        rd(3'd2, v);
        n_tests++;
        if (v !== 32'h06) begin
            n_fail++;
            $display("FAIL bsrr_clear0: got %h want 00000006", v);
        end
        wr(3'd3, 32'h0001_0001);
        rd(3'd2, v);
        n_tests++;
        if (v !== 32'h07) begin
            n_fail++;
            $display("FAIL bsrr_set_wins: got %h want 00000007", v);
        end
    endtask

    task automatic test_rise_w1c;
        logic [31:0] v;
        tb_val = 8'h00;
        cycles(LAT + 3);
        wr(3'd4, 32'h10);
        tb_val[4] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            rd(3'd6, v);
            if (k == LAT) begin
                n_tests++;
                if (v !== 32'h0 || irq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rise_early: got isr=%h irq=%b want 0/0", v, irq);
                end
            end
            if (k == LAT + 1) begin
                n_tests++;
                if (v !== 32'h10 || irq !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rise_latency: got isr=%h irq=%b want 10/1", v, irq);
                end
            end
        end
        tb_val[4] = 1'b0;
        cycles(LAT + 3);
        rd(3'd6, v);
        n_tests++;
        if (v !== 32'h10) begin
            n_fail++;
            $display("FAIL fall_no_flag: got %h want 00000010", v);
        end
        wr(3'd6, 32'h0);
        rd(3'd6, v);
        n_tests++;
        if (v !== 32'h10) begin
            n_fail++;
            $display("FAIL w1c_zero: got %h want 00000010", v);
        end
        wr(3'd6, 32'h10);
        rd(3'd6, v);
        n_tests++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_clear: got isr=%h irq=%b want 0/0", v, irq);
        end
    endtask

    task automatic test_set_wins;
        logic [31:0] v;
        wr(3'd5, 32'h20);
        tb_val[5] = 1'b1;
        cycles(LAT + 3);
        tb_val[5] = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk);
            #1;
            if (k == LAT) begin
                rd(3'd6, v);
                n_tests++;
                if (v !== 32'h0) begin
                    n_fail++;
                    $display("FAIL fall_early: got %h want 00000000", v);
                end
            end
        end
        wr(3'd6, 32'h20);
        rd(3'd6, v);
        n_tests++;
        if (v !== 32'h20 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_w1c: got isr=%h irq=%b want 20/1", v, irq);
        end
        wr(3'd6, 32'h20);
        rd(3'd6, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_after_set: got %h want 00000000", v);
        end
    endtask

    task automatic test_output_no_flag;
        logic [31:0] v;
        wr(3'd4, 32'h11);
        wr(3'd3, 32'h0001_0000);
        cycles(LAT + 3);
        wr(3'd3, 32'h0000_0001);
        cycles(LAT + 3);
        rd(3'd6, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL output_no_flag: got %h want 00000000", v);
        end
        rd(3'd1, v);
        n_tests++;
        if (v !== 32'h07) begin
            n_fail++;
            $display("FAIL output_readback: got %h want 00000007", v);
        end
    endtask

`ifdef GPIO_DEBOUNCE_EN
    task automatic test_debounce;
        logic [31:0] v;
        wr(3'd0, 32'h03);
        tb_oe = 8'hFC;
        tb_val = 8'h00;
        cycles(LAT + 3);
        wr(3'd4, 32'h04);
        tb_val[2] = 1'b1;
        cycles(3);
        tb_val[2] = 1'b0;
        cycles(LAT + 4);
        rd(3'd1, v);
        n_tests++;
        if (v !== 32'h03) begin
            n_fail++;
            $display("FAIL db_glitch_idr: got %h want 00000003", v);
        end
        rd(3'd6, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL db_glitch_isr: got %h want 00000000", v);
        end
        tb_val[2] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == LAT) begin
                rd(3'd1, v);
                n_tests++;
                if (v !== 32'h07) begin
                    n_fail++;
                    $display("FAIL db_pulse_idr: got %h want 00000007", v);
                end
            end
            if (k == LAT + 1) begin
                rd(3'd6, v);
                n_tests++;
                if (v !== 32'h04) begin
                    n_fail++;
                    $display("FAIL db_pulse_isr: got %h want 00000004", v);
                end
            end
            if (k == 6) tb_val[2] = 1'b0;
        end
        wr(3'd6, 32'h04);
        cycles(LAT + 3);
    endtask
`endif

    task automatic test_reset_mid;
        logic [31:0] v;
        wr(3'd4, 32'h10);
        tb_val[4] = 1'b1;
        cycles(LAT + 2);
        rd(3'd6, v);
        n_tests++;
        if (v !== 32'h10) begin
            n_fail++;
            $display("FAIL pre_reset_isr: got %h want 00000010", v);
        end
        wr(3'd0, 32'hFF);
        tb_oe = 8'h00;
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_irq: got %b want 0", irq);
        end
        rd(3'd6, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_isr: got %h want 00000000", v);
        end
        rd(3'd0, v);
        n_tests++;
        if (v !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_moder: got %h want 00000000", v);
        end
        tb_oe = 8'hFF;
        tb_val = 8'hC3;
        #1;
        n_tests++;
        if (pad !== 8'hC3) begin
            n_fail++;
            $display("FAIL reset_mid_pads_z: got %h want c3", pad);
        end
        cycles(2);
        reset_n = 1'b1;
        cycles(2);
    endtask

    initial begin
        test_reset();
        test_bsrr();
        test_rise_w1c();
        test_set_wins();
        test_output_no_flag();
`ifdef GPIO_DEBOUNCE_EN
        test_debounce();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
